// File: rtl/cam_cfg_pkg.sv
// rtl/cam_cfg_pkg.sv - shared states, phase constants and default sensor register table
package cam_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_EVAL,
    ST_DONE,
    ST_FAIL
  } state_t;

  localparam logic PHASE_WR = 1'b0;
  localparam logic PHASE_RD = 1'b1;

  localparam logic [7:0] DEFAULT_DEV_ADDR = 8'hC0;

  // Entry i sits at DEFAULT_TABLE[i]; each entry is {sub_addr, data}.
  localparam int TABLE_LEN = 8;
  localparam logic [TABLE_LEN-1:0][15:0] DEFAULT_TABLE = {
    16'h1A35, 16'h1903, 16'h186A, 16'h1738,
    16'h28E0, 16'h3940, 16'h1420, 16'h1104
  };

endpackage

// File: rtl/cam_reg_sequencer_if.sv
// rtl/cam_reg_sequencer_if.sv - ena/busy transaction bus between sequencer and I2C master
interface cam_reg_sequencer_if;
  logic       ena;
  logic [7:0] addr;
  logic [7:0] sub_addr;
  logic [7:0] data_wr;
  logic       rw;
  logic [7:0] data_rd;
  logic       busy;
  logic       ack_err;

  modport master (
    output ena, addr, sub_addr, data_wr, rw,
    input  data_rd, busy, ack_err
  );

  modport slave (
    input  ena, addr, sub_addr, data_wr, rw,
    output data_rd, busy, ack_err
  );
endinterface

// File: rtl/cam_reg_rom.sv
// rtl/cam_reg_rom.sv - combinational index -> {sub_addr, data} lookup into the register table
module cam_reg_rom
  import cam_cfg_pkg::*;
#(
  parameter int NUM_REGS = 8,
  parameter int IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic [IDX_W-1:0] idx,
  output logic [7:0]       sub_addr,
  output logic [7:0]       data
);

  logic [15:0] entry;

  // Entries past NUM_REGS or past the table read as zero.
  always_comb begin
    entry = '0;
    for (int i = 0; i < TABLE_LEN; i++) begin
      if ((i < NUM_REGS) && (idx == IDX_W'(i))) begin
        entry = DEFAULT_TABLE[i];
      end
    end
  end

  assign sub_addr = entry[15:8];
  assign data     = entry[7:0];

endmodule

// File: rtl/cam_reg_sequencer.sv
// rtl/cam_reg_sequencer.sv - table-driven camera register writer with retry and optional read-back verify
module cam_reg_sequencer
  import cam_cfg_pkg::*;
#(
  parameter int         NUM_REGS    = 8,
  parameter logic [7:0] DEV_ADDR    = DEFAULT_DEV_ADDR,
  parameter int         MAX_RETRIES = 3,
  parameter int         VERIFY      = 0,
  parameter int         TIMEOUT_CYC = 1024,
  parameter int         IDX_W       = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  cam_reg_sequencer_if.master  bus,
  output logic                 done,
  output logic                 error,
  output logic [IDX_W-1:0]     err_idx,
  output logic                 active
);

  localparam int TMO_W = $clog2(TIMEOUT_CYC) + 1;

  state_t             state, state_nxt;
  logic               phase, phase_nxt;
  logic [IDX_W-1:0]   idx, idx_nxt;
  logic [3:0]         retry_cnt, retry_nxt;
  logic [TMO_W-1:0]   tmo_cnt, tmo_nxt;
  logic               prev_start;
  logic               ack_q, ack_nxt;
  logic               tmo_q, tmo_flag_nxt;
  logic [7:0]         rd_q, rd_nxt;
  logic               done_nxt, error_nxt;
  logic [IDX_W-1:0]   err_idx_nxt;
  logic               xfer_fail;
  logic               ena_r, rw_r;
  logic [7:0]         sub_r, data_r;
  logic [7:0]         rom_sub, rom_data;

  // The ROM looks at the next index so the bus fields are ready on the edge ena rises.
  cam_reg_rom #(.NUM_REGS(NUM_REGS), .IDX_W(IDX_W)) u_rom (
    .idx      (idx_nxt),
    .sub_addr (rom_sub),
    .data     (rom_data)
  );

  always_comb begin
    state_nxt    = state;
    phase_nxt    = phase;
    idx_nxt      = idx;
    retry_nxt    = retry_cnt;
    tmo_nxt      = tmo_cnt;
    ack_nxt      = ack_q;
    rd_nxt       = rd_q;
    tmo_flag_nxt = tmo_q;
    done_nxt     = done;
    error_nxt    = error;
    err_idx_nxt  = err_idx;
    // data_r still holds the table data of the entry under test during EVAL.
    xfer_fail    = ack_q | tmo_q | ((phase == PHASE_RD) && (rd_q != data_r));

    case (state)
      ST_IDLE, ST_DONE, ST_FAIL: begin
        if (start && !prev_start) begin
          state_nxt   = ST_ISSUE;
          phase_nxt   = PHASE_WR;
          idx_nxt     = '0;
          retry_nxt   = '0;
          tmo_nxt     = '0;
          done_nxt    = 1'b0;
          error_nxt   = 1'b0;
          err_idx_nxt = '0;
        end
      end
      ST_ISSUE: begin
        if (bus.busy) begin
          state_nxt = ST_WAIT;
        end else if (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1)) begin
          state_nxt    = ST_EVAL;
          tmo_flag_nxt = 1'b1;
          ack_nxt      = 1'b0;
        end else begin
          tmo_nxt = tmo_cnt + 1'b1;
        end
      end
      ST_WAIT: begin
        if (!bus.busy) begin
          state_nxt    = ST_EVAL;
          ack_nxt      = bus.ack_err;
          rd_nxt       = bus.data_rd;
          tmo_flag_nxt = 1'b0;
        end
      end
      ST_EVAL: begin
        tmo_nxt = '0;
        if (xfer_fail) begin
          if (retry_cnt < 4'(MAX_RETRIES)) begin
            retry_nxt = retry_cnt + 1'b1;
            phase_nxt = PHASE_WR;
            state_nxt = ST_ISSUE;
          end else begin
            state_nxt   = ST_FAIL;
            error_nxt   = 1'b1;
            err_idx_nxt = idx;
          end
        end else if ((phase == PHASE_WR) && (VERIFY != 0)) begin
          phase_nxt = PHASE_RD;
          state_nxt = ST_ISSUE;
        end else if (idx == IDX_W'(NUM_REGS - 1)) begin
          state_nxt = ST_DONE;
          done_nxt  = 1'b1;
        end else begin
          idx_nxt   = idx + 1'b1;
          retry_nxt = '0;
          phase_nxt = PHASE_WR;
          state_nxt = ST_ISSUE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      phase      <= PHASE_WR;
      idx        <= '0;
      retry_cnt  <= '0;
      tmo_cnt    <= '0;
      prev_start <= 1'b0;
      ack_q      <= 1'b0;
      rd_q       <= '0;
      tmo_q      <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      err_idx    <= '0;
      active     <= 1'b0;
      ena_r      <= 1'b0;
      rw_r       <= 1'b0;
      sub_r      <= '0;
      data_r     <= '0;
    end else begin
      state      <= state_nxt;
      phase      <= phase_nxt;
      idx        <= idx_nxt;
      retry_cnt  <= retry_nxt;
      tmo_cnt    <= tmo_nxt;
      prev_start <= start;
      ack_q      <= ack_nxt;
      rd_q       <= rd_nxt;
      tmo_q      <= tmo_flag_nxt;
      done       <= done_nxt;
      error      <= error_nxt;
      err_idx    <= err_idx_nxt;
      active     <= (state_nxt == ST_ISSUE) || (state_nxt == ST_WAIT) || (state_nxt == ST_EVAL);
      ena_r      <= (state_nxt == ST_ISSUE);
      if ((state_nxt == ST_ISSUE) && (state != ST_ISSUE)) begin
        sub_r  <= rom_sub;
        data_r <= rom_data;
        rw_r   <= phase_nxt;
      end
    end
  end

  assign bus.ena      = ena_r;
  assign bus.addr     = {DEV_ADDR[7:1], 1'b0};
  assign bus.sub_addr = sub_r;
  assign bus.data_wr  = data_r;
  assign bus.rw       = rw_r;

endmodule

// File: tb/tb_cam_reg_sequencer.sv
// tb/tb_cam_reg_sequencer.sv - scoreboard bench driving four parameterisations through one I2C master model
module tb_cam_reg_sequencer;

  localparam int N        = 4;
  localparam int BUSY_CYC = 20;

  typedef struct packed {
    logic [7:0] sub;
    logic       rw;
    logic [7:0] data;
  } txn_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_a  [N];
  logic       done_a   [N];
  logic       error_a  [N];
  logic       active_a [N];
  logic       ena_a    [N];
  logic       rw_a     [N];
  logic [7:0] sub_a    [N];
  logic [7:0] wd_a     [N];
  logic [7:0] addr_a   [N];
  logic [2:0] eidx_a   [N];

  logic       busy_m = 1'b0;
  logic       ack_m  = 1'b0;
  logic [7:0] rd_m   = 8'h00;

  int nchecks = 0;
  int nerrs   = 0;

  txn_t exp_q[$];
  int   sel         = 0;
  logic dead        = 1'b0;
  int   exp_ena_len = 1;
  int   epoch       = 0;
  logic [7:0] nack_sub  = 8'hFF;
  int         nack_times = 0;
  logic [7:0] bad_sub   = 8'hFF;
  int         bad_times = 0;

  logic [15:0] tbl [8] = '{16'h1104, 16'h1420, 16'h3940, 16'h28E0,
                           16'h1738, 16'h186A, 16'h1903, 16'h1A35};

  always #5 clk = ~clk;

  for (genvar k = 0; k < N; k++) begin : g_dut
    cam_reg_sequencer_if bus ();
    assign bus.busy    = busy_m;
    assign bus.ack_err = ack_m;
    assign bus.data_rd = rd_m;
    assign ena_a[k]    = bus.ena;
    assign rw_a[k]     = bus.rw;
    assign sub_a[k]    = bus.sub_addr;
    assign wd_a[k]     = bus.data_wr;
    assign addr_a[k]   = bus.addr;

    cam_reg_sequencer #(
      .NUM_REGS    (8),
      .DEV_ADDR    (8'hC0),
      .MAX_RETRIES (k == 1 ? 2 : (k == 3 ? 0 : 3)),
      .VERIFY      (k == 2 ? 1 : 0),
      .TIMEOUT_CYC (k == 3 ? 16 : 1024)
    ) u_dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start_a[k]),
      .bus     (bus.master),
      .done    (done_a[k]),
      .error   (error_a[k]),
      .err_idx (eidx_a[k]),
      .active  (active_a[k])
    );
  end

  // I2C master model plus scoreboard monitor for the selected instance.
  int         cnt = 0;
  int         seen_epoch = 0;
  int         nack_hits = 0;
  int         bad_hits = 0;
  int         ena_run = 0;
  logic [7:0] cur_sub = 8'h00;
  logic       nxt_ack;
  logic [7:0] nxt_rd;
  logic [7:0] mem [256];

  always @(negedge clk) begin
    txn_t e;
    logic [16:0] act_v, exp_v;
    logic nack, bad;
    if (epoch != seen_epoch) begin
      nack_hits  = 0;
      bad_hits   = 0;
      seen_epoch = epoch;
    end
    if (busy_m) begin
      cnt--;
      if (cnt == 0) begin
        busy_m = 1'b0;
        ack_m  = nxt_ack;
        rd_m   = nxt_rd;
      end
    end else if (ena_a[sel] && !dead && !rst) begin
      cur_sub = sub_a[sel];
      nchecks++;
      if (exp_q.size() == 0) begin
        nerrs++;
        $display("FAIL unexpected_txn: got sub=%02h rw=%0b, required no transfer", sub_a[sel], rw_a[sel]);
      end else begin
        e     = exp_q.pop_front();
        act_v = {addr_a[sel] == 8'hC0 ? 8'h00 : addr_a[sel], rw_a[sel], rw_a[sel] ? 8'h00 : wd_a[sel]};
        exp_v = {8'h00, e.rw, e.rw ? 8'h00 : e.data};
        if (sub_a[sel] != e.sub || act_v != exp_v) begin
          nerrs++;
          $display("FAIL txn: got addr=%02h sub=%02h rw=%0b data=%02h, required addr=c0 sub=%02h rw=%0b data=%02h",
                   addr_a[sel], sub_a[sel], rw_a[sel], wd_a[sel], e.sub, e.rw, e.data);
        end
      end
      nack = (sub_a[sel] == nack_sub) && (nack_hits < nack_times);
      if (sub_a[sel] == nack_sub) nack_hits++;
      nxt_rd = 8'h00;
      if (rw_a[sel]) begin
        bad = (sub_a[sel] == bad_sub) && (bad_hits < bad_times);
        if (sub_a[sel] == bad_sub) bad_hits++;
        nxt_rd = bad ? 8'h05 : mem[sub_a[sel]];
      end else if (!nack) begin
        mem[sub_a[sel]] = wd_a[sel];
      end
      nxt_ack = nack;
      busy_m  = 1'b1;
      cnt     = BUSY_CYC;
    end
    if (ena_a[sel]) begin
      ena_run++;
    end else if (ena_run > 0) begin
      nchecks++;
      if (ena_run != exp_ena_len) begin
        nerrs++;
        $display("FAIL ena_len: got %0d cycles, required %0d", ena_run, exp_ena_len);
      end
      ena_run = 0;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    nchecks++;
    if (act != exp) begin
      nerrs++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] s, input logic rw, input logic [7:0] d);
    txn_t t;
    t.sub = s; t.rw = rw; t.data = d;
    exp_q.push_back(t);
  endtask

  task automatic push_idx(input int i);
    logic [15:0] v;
    v = tbl[i];
    push(v[15:8], 1'b0, v[7:0]);
  endtask

  task automatic wait_end(input int k, input string name);
    int c;
    c = 0;
    while (!(done_a[k] || error_a[k]) && c < 5000) begin
      @(negedge clk);
      c++;
    end
    check({name, "_finished"}, int'(c < 5000), 1);
    repeat (30) @(negedge clk);
    check({name, "_pending"}, exp_q.size(), 0);
  endtask

  task automatic run(input int k, input string name);
    sel = k;
    @(negedge clk);
    start_a[k] = 1'b1;
    @(negedge clk);
    start_a[k] = 1'b0;
    wait_end(k, name);
  endtask

  initial begin
    int c;
    rst = 1'b1;
    for (int k = 0; k < N; k++) start_a[k] = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ena", ena_a[0], 0);
    check("rst_active", active_a[0], 0);
    check("rst_done", done_a[0], 0);
    check("rst_error", error_a[0], 0);
    check("rst_sub_addr", sub_a[0], 0);
    check("rst_data_wr", wd_a[0], 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // all transfers ACKed
    for (int i = 0; i < 8; i++) push_idx(i);
    run(0, "ackall");
    check("ackall_done", done_a[0], 1);
    check("ackall_error", error_a[0], 0);

    // entry 3 NACKed twice then accepted
    epoch++; nack_sub = 8'h28; nack_times = 2;
    for (int i = 0; i < 8; i++) begin
      push_idx(i);
      if (i == 3) begin push_idx(3); push_idx(3); end
    end
    run(0, "nack2");
    check("nack2_done", done_a[0], 1);
    check("nack2_error", error_a[0], 0);

    // entry 5 always NACKed, two retries allowed
    epoch++; nack_sub = 8'h18; nack_times = 1000;
    for (int i = 0; i < 6; i++) push_idx(i);
    push_idx(5); push_idx(5);
    run(1, "nackall");
    check("nackall_error", error_a[1], 1);
    check("nackall_err_idx", eidx_a[1], 5);
    check("nackall_done", done_a[1], 0);
    repeat (100) @(negedge clk);
    check("nackall_active", active_a[1], 0);

    // verify mode, first read-back of sub 11 corrupted
    epoch++; nack_sub = 8'hFF; nack_times = 0; bad_sub = 8'h11; bad_times = 1;
    push(8'h11, 1'b0, 8'h04); push(8'h11, 1'b1, 8'h00);
    for (int i = 0; i < 8; i++) begin
      push_idx(i);
      push(tbl[i][15:8], 1'b1, 8'h00);
    end
    run(2, "verify");
    check("verify_done", done_a[2], 1);
    check("verify_error", error_a[2], 0);

    // busy never rises: one 16-cycle ena then error at entry 0
    epoch++; bad_sub = 8'hFF; bad_times = 0;
    dead = 1'b1; exp_ena_len = 16;
    run(3, "timeout");
    check("timeout_error", error_a[3], 1);
    check("timeout_err_idx", eidx_a[3], 0);
    check("timeout_done", done_a[3], 0);
    dead = 1'b0; exp_ena_len = 1;

    // asynchronous reset while waiting on entry 4
    epoch++;
    for (int i = 0; i < 5; i++) push_idx(i);
    sel = 0;
    @(negedge clk); start_a[0] = 1'b1;
    @(negedge clk); start_a[0] = 1'b0;
    c = 0;
    while (!(busy_m && cur_sub == 8'h17) && c < 2000) begin
      @(negedge clk);
      c++;
    end
    check("rstmid_reached", int'(c < 2000), 1);
    repeat (3) @(negedge clk);
    check("rstmid_active_before", active_a[0], 1);
    rst = 1'b1;
    #1;
    check("rstmid_ena", ena_a[0], 0);
    check("rstmid_active", active_a[0], 0);
    check("rstmid_done", done_a[0], 0);
    @(negedge clk);
    rst = 1'b0;
    c = 0;
    while (busy_m && c < 100) begin
      @(negedge clk);
      c++;
    end
    check("rstmid_pending", exp_q.size(), 0);

    // restart with start held high through DONE
    for (int i = 0; i < 8; i++) push_idx(i);
    start_a[0] = 1'b1;
    wait_end(0, "held");
    repeat (200) @(negedge clk);
    check("held_done", done_a[0], 1);
    check("held_active", active_a[0], 0);
    check("held_pending", exp_q.size(), 0);
    start_a[0] = 1'b0;
    repeat (5) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cam_reg_sequencer.md
# cam_reg_sequencer

Table-driven camera register initializer that sits between the board-level start control and the I2C master. On a start request it writes `NUM_REGS` (sub-address, data) pairs to the sensor at `DEV_ADDR` through the master's ena/busy handshake. Optionally it reads each register back and compares it with the written value. It retries failed transfers, covering NACK, busy timeout and verify mismatch, then reports `done` or `error` with the failing table index.

## Interface
Parameters:
- `NUM_REGS`, 8: table entries, 1..256.
- `DEV_ADDR`, 8'hC0: 8-bit write-form device address; bit 0 is always driven 0.
- `MAX_RETRIES`, 3: extra attempts per entry after the first, 0..15.
- `VERIFY`, 0: when 1, each write is followed by a read-back compare.
- `TIMEOUT_CYC`, 1024: maximum cycles `ena` may stay high without `busy` rising.
- `IDX_W`, $clog2(NUM_REGS) (min 1): index width, derived.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: request; the rising edge is used.
- `ena` out 1: transaction request to the I2C master.
- `addr` out 8: device address, = `DEV_ADDR`.
- `sub_addr` out 8: register sub-address.
- `data_wr` out 8: write data.
- `rw` out 1: 0 = write, 1 = read.
- `data_rd` in 8: read data from the master.
- `busy` in 1: master busy.
- `ack_err` in 1: master NACK flag, valid while `busy` falls.
- `done` out 1: sequence completed successfully.
- `error` out 1: sequence aborted.
- `err_idx` out IDX_W: failing entry index.
- `active` out 1: sequence in progress.

## Operation
- The states are IDLE, ISSUE, WAIT, EVAL, DONE and FAIL. A phase bit marks the current transfer as WR or RD.
- **Start detection:** `prev_start` is registered every cycle. A rising edge of `start` is acted on only in IDLE, DONE or FAIL. It clears `done`, `error`, `err_idx`, `idx` and `retry_cnt`, sets phase = WR and enters ISSUE.
- **ISSUE:**
  - `ena` = 1.
  - `sub_addr` and `data_wr` come from the ROM at `idx`.
  - `rw` = phase.
  - All outputs stay stable until `busy` is sampled high; then `ena` goes to 0 and the state moves to WAIT.
  - If `TIMEOUT_CYC` cycles pass with `busy` still low, `ena` goes to 0 and EVAL is entered with failure flagged.
- **WAIT:** when `busy` is sampled low, `ack_err` and `data_rd` are captured and the state moves to EVAL.
- **EVAL:**
  - Failure is `ack_err`, a timeout, or (RD phase) `data_rd` != ROM data.
  - On failure with `retry_cnt` < `MAX_RETRIES`: increment `retry_cnt`, set phase = WR and return to ISSUE for the same `idx`.
  - On failure with `retry_cnt` = `MAX_RETRIES`: go to FAIL.
  - On success in WR phase with `VERIFY` = 1: set phase = RD and return to ISSUE.
  - On any other success: if `idx` = `NUM_REGS`-1, go to DONE; otherwise increment `idx`, clear `retry_cnt`, set phase = WR and return to ISSUE.
- **DONE:** `done` = 1, held until the next start edge or reset.
- **FAIL:** `error` = 1 and `err_idx` = `idx`, held until the next start edge or reset.
- `active` = 1 in ISSUE, WAIT and EVAL.
- A `start` edge during a sequence is ignored. `prev_start` still tracks, so a held-high `start` does not retrigger.

## Timing
- **Reset values:** every output is 0 (`addr` = `DEV_ADDR` is allowed), state = IDLE, counters = 0. Reset takes effect immediately, including mid-transfer.
- **Registered outputs:** all outputs are registered.
  - The start edge is sampled at edge E; `ena` = 1 from edge E.
  - `busy` is sampled high at edge B; `ena` = 0 from edge B.
  - `busy` is sampled low at edge C; EVAL is active for the cycle after C.
  - The next ISSUE, and `ena` = 1, follow from edge C+1.
- **Per-entry overhead:** 2 cycles beyond the master's busy time for each transfer.
- **Timeout counter:**
  - Counts cycles in ISSUE and resets on entry to ISSUE.
  - Fires when the count equals `TIMEOUT_CYC`-1.
  - `busy` rising on that same cycle counts as success; busy wins.
- **Simultaneous events:**
  - `ack_err` with a readback mismatch counts as one failure.
  - `NUM_REGS` = 1 goes directly from EVAL to DONE.

## Structure
- **Package `cam_cfg_pkg`:**
  - State enum and the WR/RD phase constants.
  - Default register table as a constant array of {sub_addr, data}: 11/04, 14/20, 39/40, 28/E0, 17/38, 18/6A, 19/03, 1A/35.
  - Default `DEV_ADDR`.
- **Sub-module `cam_reg_rom`:** combinational lookup from `idx` to {sub_addr, data}, parameterised by `NUM_REGS`. It is the only place the table is referenced.

## Test plan
- Default table, with an I2C master model that ACKs everything (busy high 20 cycles) -> 8 writes with sub_addr 11,14,39,28,17,18,19,1A in order; `done` = 1, `error` = 0; each `ena` pulse drops on the edge after busy is sampled high.
- Entry 3 NACKed twice, `MAX_RETRIES` = 3 -> sub_addr 28 is written 3 times, the sequence continues and `done` = 1.
- Entry 5 always NACKed, `MAX_RETRIES` = 2 -> 3 attempts at sub_addr 18, `error` = 1, `err_idx` = 5, no further `ena`.
- `VERIFY` = 1, model returns 8'h05 for sub_addr 11 -> WR 11/04, RD 11, mismatch, retry; with the model fixed on the retry, the sequence proceeds to DONE.
- `busy` held low, `TIMEOUT_CYC` = 16, `MAX_RETRIES` = 0 -> `ena` high for exactly 16 cycles, then `error` = 1, `err_idx` = 0.
- `rst` pulsed while WAIT is at idx 4 -> `ena`, `active` and `done` go to 0 immediately; a new `start` edge restarts at sub_addr 11. `start` held high through DONE does not retrigger.
